// File: rtl/servant_pkg.sv
// Shared definitions for the servant round-robin arbiter: FSM encoding,
// master-count limit and an index-width helper.
package servant_pkg;

  // Largest supported number of master ports
  localparam int MAX_MASTERS = 8;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Bits needed to hold a master index (never less than one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational round-robin picker: the search starts at the master just
// after the last served one and wraps around; returns the winner as one-hot
// and as an index.
module servant_rr_pick
  import servant_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]              req_i,
  input  logic [idx_width(N)-1:0]   last_i,
  output logic [N-1:0]              win_o,
  output logic [idx_width(N)-1:0]   idx_o
);

  localparam int IW = idx_width(N);

  // Walk the requests in priority order; the first hit claims the grant
  always_comb begin
    logic found;
    logic hit;
    int   k;
    found = 1'b0;
    hit   = 1'b0;
    k     = 0;
    win_o = '0;
    idx_o = '0;
    for (int i = 1; i <= N; i++) begin
      k        = (int'(last_i) + i) % N;
      hit      = req_i[k] & ~found;
      win_o[k] = hit;
      idx_o    = hit ? IW'(k) : idx_o;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/servant_arbiter_rr.sv
// Round-robin arbiter sharing one cyc-only slave port among NUM_MASTERS
// masters. One-cycle arbitration in IDLE, transfer held in BUSY until ack,
// master abort, or optional timeout.
module servant_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_MASTERS*AW-1:0]     i_m_adr,
  input  logic [NUM_MASTERS*DW-1:0]     i_m_dat,
  input  logic [NUM_MASTERS*(DW/8)-1:0] i_m_sel,
  input  logic [NUM_MASTERS-1:0]        i_m_we,
  input  logic [NUM_MASTERS-1:0]        i_m_cyc,
  output logic [DW-1:0]                 o_m_rdt,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [NUM_MASTERS-1:0]        o_grant,
  output logic [AW-1:0]                 o_s_adr,
  output logic [DW-1:0]                 o_s_dat,
  output logic [(DW/8)-1:0]             o_s_sel,
  output logic                          o_s_we,
  output logic                          o_s_cyc,
  input  logic [DW-1:0]                 i_s_rdt,
  input  logic                          i_s_ack
);

  import servant_pkg::*;

  localparam int SW      = DW / 8;
  localparam int IW      = idx_width(NUM_MASTERS);
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last allowed BUSY cycle
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q,  gidx_d;
  logic [IW-1:0]          last_q,  last_d;
  logic [CW-1:0]          cnt_q,   cnt_d;

  logic [NUM_MASTERS-1:0] pick_win_s;
  logic [IW-1:0]          pick_idx_s;
  logic                   g_cyc_s;
  logic                   timeout_hit_s;

  servant_rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req_i  (i_m_cyc),
    .last_i (last_q),
    .win_o  (pick_win_s),
    .idx_o  (pick_idx_s)
  );

  // grant_q is all-zero outside BUSY, so masking with it also gates by state
  assign g_cyc_s       = |(grant_q & i_m_cyc);
  assign timeout_hit_s = (TIMEOUT != 0) && (state_q == ST_BUSY) && (cnt_q == TO_LAST);

  // State register: FSM, grant, served-master history and timeout counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, finish on ack/abort/timeout in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_m_cyc) begin
          state_d = ST_BUSY;
          grant_d = pick_win_s;
          gidx_d  = pick_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_BUSY: begin
        // Ack, abort and timeout all end the transfer the same way
        if (i_s_ack || !g_cyc_s || timeout_hit_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
        end else begin
          cnt_d = (TIMEOUT != 0) ? (cnt_q + CW'(1)) : '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: route the granted master to the slave and steer ack/err back
  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      o_s_adr = o_s_adr | ({AW{grant_q[k]}} & i_m_adr[k*AW +: AW]);
      o_s_dat = o_s_dat | ({DW{grant_q[k]}} & i_m_dat[k*DW +: DW]);
      o_s_sel = o_s_sel | ({SW{grant_q[k]}} & i_m_sel[k*SW +: SW]);
      o_s_we  = o_s_we  | (grant_q[k] & i_m_we[k]);
    end
    // Cyc is withdrawn in the timeout cycle; no path from i_s_ack to o_s_cyc
    o_s_cyc = g_cyc_s & ~timeout_hit_s;
    o_m_ack = grant_q & {NUM_MASTERS{i_s_ack}};
    // Ack in the same cycle beats the timeout; an aborting master gets nothing
    o_m_err = grant_q & {NUM_MASTERS{timeout_hit_s & g_cyc_s & ~i_s_ack}};
    o_m_rdt = i_s_rdt;
    o_grant = grant_q;
  end

endmodule

// File: tb/tb_servant_arbiter_rr.sv
// Directed bench for servant_arbiter_rr: a 2-master instance without timeout
// and a 4-master instance with TIMEOUT=8 share clock and reset.
module tb_servant_arbiter_rr;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_MASTERS=2, no timeout
  logic [63:0] a_adr, a_dat;
  logic [7:0]  a_sel;
  logic [1:0]  a_we, a_cyc, a_ack, a_err, a_grant;
  logic [31:0] a_rdt, a_sadr, a_sdat, a_srdt;
  logic [3:0]  a_ssel;
  logic        a_swe, a_scyc, a_sack;

  // Instance B: NUM_MASTERS=4, TIMEOUT=8
  logic [127:0] b_adr, b_dat;
  logic [15:0]  b_sel;
  logic [3:0]   b_we, b_cyc, b_ack, b_err, b_grant;
  logic [31:0]  b_rdt, b_sadr, b_sdat, b_srdt;
  logic [3:0]   b_ssel;
  logic         b_swe, b_scyc, b_sack;

  servant_arbiter_rr #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_adr(a_adr), .i_m_dat(a_dat), .i_m_sel(a_sel), .i_m_we(a_we), .i_m_cyc(a_cyc),
    .o_m_rdt(a_rdt), .o_m_ack(a_ack), .o_m_err(a_err), .o_grant(a_grant),
    .o_s_adr(a_sadr), .o_s_dat(a_sdat), .o_s_sel(a_ssel), .o_s_we(a_swe), .o_s_cyc(a_scyc),
    .i_s_rdt(a_srdt), .i_s_ack(a_sack)
  );

  servant_arbiter_rr #(.NUM_MASTERS(4), .AW(32), .DW(32), .TIMEOUT(8)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_adr(b_adr), .i_m_dat(b_dat), .i_m_sel(b_sel), .i_m_we(b_we), .i_m_cyc(b_cyc),
    .o_m_rdt(b_rdt), .o_m_ack(b_ack), .o_m_err(b_err), .o_grant(b_grant),
    .o_s_adr(b_sadr), .o_s_dat(b_sdat), .o_s_sel(b_ssel), .o_s_we(b_swe), .o_s_cyc(b_scyc),
    .i_s_rdt(b_srdt), .i_s_ack(b_sack)
  );

  // Count one comparison and report it when observed differs from expected
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n  = 1'b0;
    a_adr  = {32'h0000_0100, 32'h0000_0044};
    a_dat  = {32'hDEAD_BEEF, 32'h1111_1111};
    a_sel  = {4'hF, 4'h3};
    a_we   = 2'b10;
    a_cyc  = 2'b11;
    a_srdt = 32'hCAFE_F00D;
    a_sack = 1'b1;
    b_adr  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
    b_dat  = '0;
    b_sel  = 16'hFFFF;
    b_we   = 4'b0000;
    b_cyc  = 4'b0000;
    b_srdt = 32'h0;
    b_sack = 1'b0;

    // Reset holds everything quiet even with requests and a stray ack
    tick();
    tick();
    check_eq("rst_grant", 64'(a_grant), 64'h0);
    check_eq("rst_scyc", 64'(a_scyc), 64'h0);
    check_eq("rst_ack", 64'(a_ack), 64'h0);
    check_eq("rst_err", 64'(a_err), 64'h0);
    check_eq("rdt_pass", 64'(a_rdt), 64'hCAFE_F00D);

    // Release reset; arbitration takes exactly one cycle
    rst_n  = 1'b1;
    a_sack = 1'b0;
    #1;
    check_eq("idle_no_scyc", 64'(a_scyc), 64'h0);
    tick();
    check_eq("first_grant_m0", 64'(a_grant), 64'h1);
    check_eq("busy_scyc", 64'(a_scyc), 64'h1);
    check_eq("m0_adr", 64'(a_sadr), 64'h44);
    check_eq("m0_we", 64'(a_swe), 64'h0);
    tick();
    a_sack = 1'b1;
    #1;
    check_eq("ack_m0", 64'(a_ack), 64'h1);
    tick();
    a_cyc  = 2'b10;
    a_sack = 1'b0;
    #1;
    check_eq("idle_after_ack", 64'(a_grant), 64'h0);
    tick();
    check_eq("grant_m1", 64'(a_grant), 64'h2);
    check_eq("m1_adr", 64'(a_sadr), 64'h100);
    check_eq("m1_dat", 64'(a_sdat), 64'hDEAD_BEEF);
    check_eq("m1_sel", 64'(a_ssel), 64'hF);
    check_eq("m1_we", 64'(a_swe), 64'h1);
    a_sack = 1'b1;
    #1;
    check_eq("ack_m1", 64'(a_ack), 64'h2);
    tick();
    a_cyc  = 2'b00;
    a_sack = 1'b0;

    // Master abort: no ack, back to IDLE next cycle
    a_cyc = 2'b01;
    tick();
    check_eq("abort_grant", 64'(a_grant), 64'h1);
    a_cyc = 2'b00;
    #1;
    check_eq("abort_scyc", 64'(a_scyc), 64'h0);
    check_eq("abort_ack", 64'(a_ack), 64'h0);
    tick();
    check_eq("abort_idle", 64'(a_grant), 64'h0);

    // Last served is master 0, so master 1 wins; then reset mid-BUSY
    a_cyc = 2'b11;
    tick();
    check_eq("rr_after_m0", 64'(a_grant), 64'h2);
    rst_n  = 1'b0;
    a_sack = 1'b1;
    #1;
    check_eq("midrst_grant", 64'(a_grant), 64'h0);
    check_eq("midrst_ack", 64'(a_ack), 64'h0);
    check_eq("midrst_scyc", 64'(a_scyc), 64'h0);
    check_eq("midrst_sadr", 64'(a_sadr), 64'h0);
    tick();
    rst_n  = 1'b1;
    a_sack = 1'b0;
    tick();
    check_eq("postrst_m0", 64'(a_grant), 64'h1);
    a_sack = 1'b1;
    tick();
    a_cyc  = 2'b00;
    a_sack = 1'b0;
    tick();

    // Four masters requesting continuously: grants 0,1,2,3,0
    b_cyc = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      check_eq($sformatf("rr4_grant_%0d", i), 64'(b_grant), 64'(exp_g));
      check_eq($sformatf("rr4_adr_%0d", i), 64'(b_sadr), 64'((i % 4) * 16));
      b_sack = 1'b1;
      #1;
      check_eq($sformatf("rr4_ack_%0d", i), 64'(b_ack), 64'(exp_g));
      tick();
      b_sack = 1'b0;
      #1;
      check_eq($sformatf("rr4_idle_%0d", i), 64'(b_grant), 64'h0);
    end
    b_cyc = 4'b0000;

    // Timeout: master 1 is next after master 0; slave never acks
    b_cyc = 4'b0010;
    tick();
    check_eq("to_grant", 64'(b_grant), 64'h2);
    repeat (6) tick();
    check_eq("to_err_c7", 64'(b_err), 64'h0);
    check_eq("to_scyc_c7", 64'(b_scyc), 64'h1);
    tick();
    check_eq("to_err_c8", 64'(b_err), 64'h2);
    check_eq("to_scyc_c8", 64'(b_scyc), 64'h0);
    b_cyc = 4'b0100;
    tick();
    check_eq("to_err_gone", 64'(b_err), 64'h0);
    check_eq("to_idle", 64'(b_grant), 64'h0);

    // Next request arbitrated; ack in the 8th BUSY cycle beats the timeout
    tick();
    check_eq("to_next_grant", 64'(b_grant), 64'h4);
    repeat (7) tick();
    b_sack = 1'b1;
    #1;
    check_eq("to_ack_wins", 64'(b_ack), 64'h4);
    check_eq("to_ack_no_err", 64'(b_err), 64'h0);
    tick();
    b_cyc  = 4'b0000;
    b_sack = 1'b0;
    #1;
    check_eq("to_ack_idle", 64'(b_grant), 64'h0);
    check_eq("to_ack_err_after", 64'(b_err), 64'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servant_arbiter_rr.md
SERVANT_ARBITER_RR -- requirements
Module: servant_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of master ports (legal range 2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (multiple of 8); SW = DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 0, cycles in BUSY before error abort; 0 disables the timeout.
REQ-005 SHALL have ports, clock and reset first: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m_adr  in  NUM_MASTERS*AW  packed master addresses; master k occupies slice k
- i_m_dat  in  NUM_MASTERS*DW  packed master write data
- i_m_sel  in  NUM_MASTERS*SW  packed master byte selects
- i_m_we  in  NUM_MASTERS  per-master write enable
- i_m_cyc  in  NUM_MASTERS  per-master request (cyc-only bus, no stb)
- o_m_rdt  out  DW  read data, broadcast to all masters
- o_m_ack  out  NUM_MASTERS  per-master acknowledge
- o_m_err  out  NUM_MASTERS  per-master timeout error pulse
- o_grant  out  NUM_MASTERS  one-hot current grant, all-zero in IDLE
- o_s_adr / o_s_dat / o_s_sel / o_s_we  out  AW / DW / SW / 1  slave request fields
- o_s_cyc  out  1  slave request
- i_s_rdt  in  DW  slave read data
- i_s_ack  in  1  slave acknowledge

Function
REQ-006 SHALL implement FSM states IDLE and BUSY.
REQ-007 In IDLE with any i_m_cyc bit set, SHALL pick a winner by round-robin search starting at (last+1) mod NUM_MASTERS, register it as grant, and enter BUSY next cycle.
REQ-008 Arbitration latency SHALL be exactly one cycle: o_s_cyc asserts in the first BUSY cycle, never in IDLE.
REQ-009 In BUSY, o_s_adr/dat/sel/we SHALL be the granted master's slice and o_s_cyc SHALL equal that master's i_m_cyc.
REQ-010 o_m_ack[g] SHALL equal i_s_ack combinationally for the granted master g; all other ack bits 0; ack outside BUSY SHALL be ignored.
REQ-011 o_m_rdt SHALL equal i_s_rdt unconditionally.
REQ-012 On i_s_ack in BUSY: last <= g, state <= IDLE; masters drop cyc the cycle after ack, so a completed request is never re-granted.
REQ-013 If the granted master drops i_m_cyc in BUSY without ack (abort), SHALL return to IDLE next cycle, set last <= g, and issue no ack or err.
REQ-014 Timeout counter SHALL clear on entry to BUSY, increment each BUSY cycle, width clog2(TIMEOUT+1); on reaching TIMEOUT without ack SHALL pulse o_m_err[g] for one cycle, drop o_s_cyc that cycle, set last <= g, go IDLE.
REQ-015 i_s_ack and timeout in the same cycle: ack SHALL win, no err.
REQ-016 Requests arriving while BUSY SHALL wait; no preemption.
REQ-017 Round-robin wrap: after master NUM_MASTERS-1 is served, master 0 SHALL have highest priority.

Reset
REQ-018 Reset asserted SHALL force state IDLE, grant 0, last = NUM_MASTERS-1, counter 0, o_s_cyc 0, o_m_ack 0, o_m_err 0, o_grant 0.
REQ-019 Reset asserted mid-BUSY SHALL abort the transfer immediately with no ack/err; a late i_s_ack SHALL be discarded.
REQ-020 Registers SHALL resume on the first clock edge after i_rst_n deasserts; master 0 wins first contention.

Structure
REQ-021 Package servant_pkg SHALL hold the FSM state encoding and the maximum NUM_MASTERS constant.
REQ-022 Round-robin selection SHALL be sub-module servant_rr_pick (combinational; inputs request vector and last index; outputs one-hot winner and index).

Verification
REQ-023 N=2, both cyc=1 from reset -> master 0 granted; slave ack at cycle 3 -> o_m_ack=2'b01; next grant master 1.
REQ-024 N=4, all four requesting continuously -> grant order 0,1,2,3,0; no master waits more than 3 transactions.
REQ-025 N=2, master 1 write adr=0x100 dat=0xDEADBEEF sel=4'hF -> o_s_* match exactly while o_grant=2'b10.
REQ-026 TIMEOUT=8, slave never acks -> o_m_err[g] one-cycle pulse 8 BUSY cycles after grant; o_s_cyc low; next request arbitrated.
REQ-027 TIMEOUT=8, ack in 8th BUSY cycle -> ack delivered, o_m_err stays 0.
REQ-028 i_rst_n pulsed low mid-BUSY -> all outputs 0 within the reset cycle; next arbitration grants master 0.
